pcie_us_rq_arb: RTL and testbench

Round-robin arbiter that shares the UltraScale PCIe requester-request (RQ) AXI-stream channel among PORTS upstream requesters (DMA read/write engines, MSI generators). Arbitrates only at packet boundaries. Gates non-posted (NP) requests on core NP-header credit (pcie_tfc_nph_av), a local holdoff and an outstanding-NP limit. Sits directly between the requester engines and the core s_axis_rq port.

---
 rtl/pcie_us_rq_arb.sv | 154 +++++++++++++++
 tb/tb_pcie_us_rq_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_us_rq_arb.sv
// Round-robin arbiter sharing the UltraScale PCIe RQ AXI-stream among PORTS requesters.
// Arbitrates at packet boundaries; NP requests gated by header credit, holdoff and outstanding limit.
module pcie_us_rq_arb #(
   parameter int PORTS           = 4,
   parameter int DATA_WIDTH      = 64,
   parameter int KEEP_WIDTH      = DATA_WIDTH/32,
   parameter int RQ_USER_WIDTH   = 60,
   parameter int MAX_OUTSTANDING = 32,
   parameter int NP_HOLDOFF      = 2
) (
   input  logic                           user_clk,
   input  logic                           user_reset,
   input  logic [PORTS*DATA_WIDTH-1:0]    s_axis_req_tdata,
   input  logic [PORTS*KEEP_WIDTH-1:0]    s_axis_req_tkeep,
   input  logic [PORTS-1:0]               s_axis_req_tlast,
   input  logic [PORTS*RQ_USER_WIDTH-1:0] s_axis_req_tuser,
   input  logic [PORTS-1:0]               s_axis_req_tvalid,
   output logic [PORTS-1:0]               s_axis_req_tready,
   input  logic [PORTS-1:0]               s_axis_req_np,
   output logic [DATA_WIDTH-1:0]          m_axis_rq_tdata,
   output logic [KEEP_WIDTH-1:0]          m_axis_rq_tkeep,
   output logic                           m_axis_rq_tlast,
   output logic [RQ_USER_WIDTH-1:0]       m_axis_rq_tuser,
   output logic                           m_axis_rq_tvalid,
   input  logic                           m_axis_rq_tready,
   input  logic [1:0]                     pcie_tfc_nph_av,
   input  logic                           np_cpl_done,
   output logic [6:0]                     np_outstanding,
   output logic                           grant_valid,
   output logic [2:0]                     grant_index,
   output logic                           np_underflow
);

   typedef enum logic {IDLE, XFER} state_t;

   state_t      state_q;
   logic [2:0]  ptr_q;
   logic [2:0]  grant_q;
   logic        grant_valid_q;
   logic [6:0]  np_cnt_q, np_cnt_d;
   logic [2:0]  hold_q, hold_d;
   logic        uf_q, uf_d;

   logic             np_ok;
   logic [PORTS-1:0] eligible;
   logic             pick_found;
   logic [2:0]       pick_idx;
   logic             pick_np;
   logic             np_inc;
   logic             sel_valid;
   logic             sel_last;
   logic             beat_last;

   assign np_ok    = (pcie_tfc_nph_av != 2'd0) && (np_cnt_q < 7'(MAX_OUTSTANDING)) && (hold_q == 3'd0);
   assign eligible = s_axis_req_tvalid & ~(s_axis_req_np & {PORTS{~np_ok}});

   // Rotating search starting just after the last owner; blocked NP ports are skipped.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_np    = 1'b0;
      for (int unsigned k = 1; k <= PORTS; k++) begin
         for (int unsigned j = 0; j < PORTS; j++) begin
            if (!pick_found && eligible[j] &&
                ((32'(ptr_q) + k == j) || (32'(ptr_q) + k == j + PORTS))) begin
               pick_found = 1'b1;
               pick_idx   = 3'(j);
               pick_np    = s_axis_req_np[j];
            end
         end
      end
   end

   always_comb begin
      m_axis_rq_tdata   = '0;
      m_axis_rq_tkeep   = '0;
      m_axis_rq_tuser   = '0;
      sel_last          = 1'b0;
      sel_valid         = 1'b0;
      s_axis_req_tready = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         if (grant_q == 3'(i)) begin
            m_axis_rq_tdata      = s_axis_req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            m_axis_rq_tkeep      = s_axis_req_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            m_axis_rq_tuser      = s_axis_req_tuser[i*RQ_USER_WIDTH +: RQ_USER_WIDTH];
            sel_last             = s_axis_req_tlast[i];
            sel_valid            = s_axis_req_tvalid[i];
            s_axis_req_tready[i] = (state_q == XFER) && m_axis_rq_tready;
         end
      end
   end

   assign m_axis_rq_tvalid = (state_q == XFER) && sel_valid;
   assign m_axis_rq_tlast  = sel_last;
   assign beat_last        = m_axis_rq_tvalid && m_axis_rq_tready && sel_last;
   assign np_inc           = (state_q == IDLE) && pick_found && pick_np;

   // A grant and a completion in the same cycle cancel; a completion at zero only flags underflow.
   always_comb begin
      np_cnt_d = np_cnt_q;
      uf_d     = uf_q;
      if (np_inc && !np_cpl_done) begin
         np_cnt_d = np_cnt_q + 7'd1;
      end else if (!np_inc && np_cpl_done) begin
         if (np_cnt_q == 7'd0) uf_d = 1'b1;
         else                  np_cnt_d = np_cnt_q - 7'd1;
      end
   end

   always_comb begin
      hold_d = hold_q;
      if (np_inc)               hold_d = 3'(NP_HOLDOFF);
      else if (hold_q != 3'd0)  hold_d = hold_q - 3'd1;
   end

   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         state_q       <= IDLE;
         ptr_q         <= 3'(PORTS-1);
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         np_cnt_q      <= '0;
         hold_q        <= '0;
         uf_q          <= 1'b0;
      end else begin
         np_cnt_q <= np_cnt_d;
         hold_q   <= hold_d;
         uf_q     <= uf_d;
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant_q       <= pick_idx;
                  grant_valid_q <= 1'b1;
                  state_q       <= XFER;
               end
            end
            XFER: begin
               if (beat_last) begin
                  ptr_q         <= grant_q;
                  grant_valid_q <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant_valid    = grant_valid_q;
   assign grant_index    = grant_q;
   assign np_outstanding = np_cnt_q;
   assign np_underflow   = uf_q;

endmodule

// File: tb/tb_pcie_us_rq_arb.sv
// Bench for pcie_us_rq_arb: per-port packet queues feed the DUT, a packet-level arbitration
// model predicts grants/credits, and a separate monitor scoreboards every output beat.
module tb_pcie_us_rq_arb;

   localparam int P    = 4;
   localparam int DW   = 64;
   localparam int KW   = DW/32;
   localparam int UW   = 60;
   localparam int MAXO = 6;
   localparam int HOLD = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [P*DW-1:0] s_tdata;
   logic [P*KW-1:0] s_tkeep;
   logic [P-1:0]    s_tlast;
   logic [P*UW-1:0] s_tuser;
   logic [P-1:0]    s_tvalid;
   logic [P-1:0]    s_tready;
   logic [P-1:0]    s_np;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic            m_tlast;
   logic [UW-1:0]   m_tuser;
   logic            m_tvalid;
   logic            m_tready;
   logic [1:0]      nph;
   logic            cpl;
   logic [6:0]      np_out;
   logic            gvalid;
   logic [2:0]      gindex;
   logic            uflow;

   always #5 clk = ~clk;

   pcie_us_rq_arb #(
      .PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .RQ_USER_WIDTH(UW),
      .MAX_OUTSTANDING(MAXO), .NP_HOLDOFF(HOLD)
   ) dut (
      .user_clk(clk), .user_reset(rst),
      .s_axis_req_tdata(s_tdata), .s_axis_req_tkeep(s_tkeep), .s_axis_req_tlast(s_tlast),
      .s_axis_req_tuser(s_tuser), .s_axis_req_tvalid(s_tvalid), .s_axis_req_tready(s_tready),
      .s_axis_req_np(s_np),
      .m_axis_rq_tdata(m_tdata), .m_axis_rq_tkeep(m_tkeep), .m_axis_rq_tlast(m_tlast),
      .m_axis_rq_tuser(m_tuser), .m_axis_rq_tvalid(m_tvalid), .m_axis_rq_tready(m_tready),
      .pcie_tfc_nph_av(nph), .np_cpl_done(cpl), .np_outstanding(np_out),
      .grant_valid(gvalid), .grant_index(gindex), .np_underflow(uflow)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
      logic          np;
      int            gap;
   } beat_t;

   beat_t        src_q[P][$];
   beat_t        exp_q[P][$];
   int           wait_c[P];
   logic [P-1:0] acc;
   int           total = 0;
   int           bad   = 0;
   int           pkt_id = 0;

   // Reference model state: who owns the channel, where the search resumes, NP bookkeeping.
   bit m_busy;
   int m_owner, m_ptr, m_cnt, m_hold;
   bit m_uf;

   int rdy_mode   = 0;
   int nph_val    = 3;
   bit nph_rand   = 0;
   int cpl_pct    = 0;
   bit force_cpl  = 0;
   bit cpl_on_grant = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
      end
   endfunction

   function automatic void model_reset();
      m_busy = 0; m_owner = 0; m_ptr = P-1; m_cnt = 0; m_hold = 0; m_uf = 0;
   endfunction

   function automatic int pick();
      bit npok;
      int p;
      if (m_busy) return -1;
      npok = (nph != 2'd0) && (m_cnt < MAXO) && (m_hold == 0);
      for (int k = 1; k <= P; k++) begin
         p = (m_ptr + k) % P;
         if (s_tvalid[p] && (!s_np[p] || npok)) return p;
      end
      return -1;
   endfunction

   function automatic bit srcs_empty();
      for (int p = 0; p < P; p++) if (src_q[p].size() != 0) return 0;
      return 1;
   endfunction

   task automatic add_pkt(int p, int n, bit np, int gap);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.d   = {8'(p), 16'(pkt_id), 8'(i), $urandom()};
         b.k   = KW'($urandom());
         b.u   = UW'({$urandom(), $urandom()});
         b.l   = (i == n-1);
         b.np  = np;
         b.gap = gap;
         src_q[p].push_back(b);
         exp_q[p].push_back(b);
      end
      pkt_id++;
   endtask

   task automatic step();
      int g;
      bit inc;
      logic [P-1:0] want_rdy;
      @(negedge clk);
      for (int p = 0; p < P; p++) begin
         if (acc[p]) begin
            src_q[p].delete(0);
            wait_c[p] = (src_q[p].size() > 0) ? src_q[p][0].gap : 0;
         end
         if (wait_c[p] > 0) begin
            s_tvalid[p] = 1'b0; s_np[p] = 1'b0; wait_c[p]--;
         end else if (src_q[p].size() > 0) begin
            s_tdata[p*DW +: DW] = src_q[p][0].d;
            s_tkeep[p*KW +: KW] = src_q[p][0].k;
            s_tuser[p*UW +: UW] = src_q[p][0].u;
            s_tlast[p]  = src_q[p][0].l;
            s_np[p]     = src_q[p][0].np;
            s_tvalid[p] = 1'b1;
         end else begin
            s_tvalid[p] = 1'b0; s_np[p] = 1'b0;
         end
      end
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = 1'($urandom());
         default: m_tready = ~m_tready;
      endcase
      nph = nph_rand ? 2'($urandom()) : 2'(nph_val);
      g = pick();
      cpl = force_cpl || (cpl_on_grant && g >= 0 && s_np[g]) ||
            (m_cnt > 0 && int'($urandom_range(0, 99)) < cpl_pct);
      #1;
      chk("grant_valid", 64'(gvalid), 64'(m_busy));
      if (m_busy) chk("grant_index", 64'(gindex), 64'(m_owner));
      chk("np_outstanding", 64'(np_out), 64'(m_cnt));
      chk("np_underflow", 64'(uflow), 64'(m_uf));
      chk("m_tvalid", 64'(m_tvalid), 64'(m_busy && s_tvalid[m_owner]));
      want_rdy = '0;
      if (m_busy) want_rdy[m_owner] = m_tready;
      chk("s_tready", 64'(s_tready), 64'(want_rdy));
      acc = '0;
      if (m_busy && s_tvalid[m_owner] && m_tready) acc[m_owner] = 1'b1;
      inc = 0;
      if (!m_busy) begin
         if (g >= 0) begin m_busy = 1; m_owner = g; inc = s_np[g]; end
      end else if (s_tvalid[m_owner] && m_tready && s_tlast[m_owner]) begin
         m_busy = 0; m_ptr = m_owner;
      end
      if (inc) m_hold = HOLD;
      else if (m_hold > 0) m_hold--;
      if (inc && !cpl) m_cnt++;
      else if (!inc && cpl) begin
         if (m_cnt == 0) m_uf = 1;
         else m_cnt--;
      end
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic run_until_idle(int maxc);
      int c = 0;
      while (!(srcs_empty() && !m_busy) && c < maxc) begin step(); c++; end
      if (!(srcs_empty() && !m_busy)) chk("drain_timeout", 64'(c), 64'(maxc + 1));
      step();
   endtask

   task automatic drain_np();
      int c = 0;
      cpl_pct = 100;
      while (m_cnt != 0 && c < 100) begin step(); c++; end
      cpl_pct = 0;
      step();
      chk("np_drained", 64'(np_out), 64'd0);
   endtask

   task automatic clear_all();
      for (int p = 0; p < P; p++) begin
         src_q[p].delete();
         exp_q[p].delete();
         wait_c[p] = 0;
      end
      acc = '0; s_tvalid = '0; s_np = '0; cpl = 1'b0;
      model_reset();
   endtask

   // Scoreboard monitor: every accepted output beat must be the next expected beat of its port.
   initial begin
      int g;
      beat_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst === 1'b0 && m_tvalid && m_tready) begin
            g = int'(gindex);
            if (g >= P || exp_q[g].size() == 0) begin
               total++; bad++;
               $display("FAIL sb_unexpected: got beat on port %0d want none at %0t", g, $time);
            end else begin
               e = exp_q[g].pop_front();
               chk("sb_tdata", m_tdata, e.d);
               chk("sb_tkeep", 64'(m_tkeep), 64'(e.k));
               chk("sb_tuser", 64'(m_tuser), 64'(e.u));
               chk("sb_tlast", 64'(m_tlast), 64'(e.l));
            end
         end
      end
   end

   initial begin
      bit hit;
      int c;
      rst = 1'b1;
      s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0; s_tvalid = '0; s_np = '0;
      m_tready = 1'b1; nph = 2'd3; cpl = 1'b0;
      clear_all();
      #2;
      chk("rst_grant_valid", 64'(gvalid), 64'd0);
      chk("rst_grant_index", 64'(gindex), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_np_out", 64'(np_out), 64'd0);
      chk("rst_underflow", 64'(uflow), 64'd0);
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;

      // Posted 3-beat packets on ports 0,1,2
      add_pkt(0, 3, 0, 0); add_pkt(1, 3, 0, 0); add_pkt(2, 3, 0, 0);
      run_until_idle(60);

      // Back-to-back single-beat NP on port 1 with full credit
      for (int i = 0; i < 4; i++) add_pkt(1, 1, 1, 0);
      run_until_idle(60);
      chk("np_after_4", 64'(np_out), 64'd4);
      drain_np();

      // No NP credit: posted port 3 overtakes NP port 0
      nph_val = 0;
      add_pkt(0, 1, 1, 0); add_pkt(3, 2, 0, 0);
      run(8);
      chk("np_held_count", 64'(np_out), 64'd0);
      chk("np_held_valid", 64'(s_tvalid[0]), 64'd1);
      nph_val = 1;
      run_until_idle(20);
      chk("np_credit_grant", 64'(np_out), 64'd1);
      nph_val = 3;
      drain_np();

      // Outstanding limit
      for (int i = 0; i < MAXO + 1; i++) add_pkt(2, 1, 1, 0);
      run(40);
      chk("limit_count", 64'(np_out), 64'(MAXO));
      chk("limit_blocked", 64'(s_tvalid[2] && !gvalid), 64'd1);
      force_cpl = 1; step(); force_cpl = 0;
      run_until_idle(20);
      chk("limit_refill", 64'(np_out), 64'(MAXO));
      force_cpl = 1; step(); force_cpl = 0;
      step();
      add_pkt(2, 1, 1, 0);
      cpl_on_grant = 1;
      run_until_idle(20);
      cpl_on_grant = 0;
      chk("grant_cpl_same", 64'(np_out), 64'(MAXO - 1));
      drain_np();

      // Core backpressure toggling during a 4-beat packet with a competitor waiting
      rdy_mode = 2;
      add_pkt(0, 4, 0, 0);
      run(2);
      add_pkt(2, 1, 0, 0);
      run_until_idle(40);
      rdy_mode = 0;

      // Randomized traffic
      nph_rand = 1; rdy_mode = 1; cpl_pct = 15;
      for (int n = 0; n < 1500; n++) begin
         for (int p = 0; p < P; p++)
            if (src_q[p].size() < 8 && $urandom_range(0, 99) < 10)
               add_pkt(p, int'($urandom_range(1, 5)), ($urandom_range(0, 99) < 40),
                       int'($urandom_range(0, 2)));
         step();
      end
      nph_rand = 0; nph_val = 3; cpl_pct = 0;
      run_until_idle(600);
      drain_np();

      // Reset in the middle of a transfer with 5 NP outstanding
      rdy_mode = 1;
      for (int i = 0; i < 5; i++) add_pkt(1, 1, 1, 0);
      add_pkt(3, 10, 0, 1);
      hit = 0; c = 0;
      while (!hit && c < 200) begin
         step(); c++;
         hit = m_busy && (m_cnt == 5);
      end
      chk("reach_count5", 64'(hit), 64'd1);
      @(negedge clk);
      #1;
      chk("pre_rst_count", 64'(np_out), 64'd5);
      chk("pre_rst_grant", 64'(gvalid), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
      chk("mid_rst_count", 64'(np_out), 64'd0);
      chk("mid_rst_grant", 64'(gvalid), 64'd0);
      clear_all();
      @(negedge clk);
      #3 rst = 1'b0;
      rdy_mode = 0;

      // Completion with nothing outstanding
      force_cpl = 1; step(); force_cpl = 0;
      run(5);
      chk("underflow_sticky", 64'(uflow), 64'd1);
      chk("underflow_count", 64'(np_out), 64'd0);

      add_pkt(2, 2, 0, 0);
      run_until_idle(20);
      for (int p = 0; p < P; p++) chk("sb_leftover", 64'(exp_q[p].size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
